// File: rtl/button_count_ctrl.sv
// button_count_ctrl: debounced clear/count buttons drive a 4-bit counter with hold-to-repeat.
// A count button already held when reset ends is ignored until it has been seen released.
module button_count_ctrl #(
  parameter int DEBOUNCE_CYC = 120000,
  parameter int REPEAT_DLY   = 6000000,
  parameter int REPEAT_PER   = 1200000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] pmod,
  output logic [3:0] led,
  output logic       inc_pulse
);
  localparam int TMAX = REPEAT_DLY > REPEAT_PER ? REPEAT_DLY : REPEAT_PER;
  localparam int TW = $clog2(TMAX + 1);
  localparam int CW = $clog2(DEBOUNCE_CYC + 1);
  typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;
  logic [1:0] rsync, vld, s1, s2, db, db_d;
  logic [CW-1:0] cnt [2];
  logic rst_i, armed, press, rel, clr, expired, inc_req;
  logic [TW-1:0] tmr, tmr_nxt;
  state_t state, state_nxt;
  assign rst_i = rsync[1];
  // reset asserts immediately, releases two clk edges later
  always_ff @(posedge clk or negedge rst)
    if (!rst) rsync <= '0;
    else rsync <= {rsync[0], 1'b1};
  always_ff @(posedge clk or negedge rst_i)
    if (!rst_i) begin
      s1 <= '1;
      s2 <= '1;
      db_d <= '1;
      vld <= '0;
      armed <= 1'b0;
    end else begin
      s1 <= pmod;
      s2 <= s1;
      db_d <= db;
      vld <= {vld[0], 1'b1};
      armed <= armed | (vld[1] & s2[1] & db[1]);
    end
  always_ff @(posedge clk or negedge rst_i)
    if (!rst_i) begin
      for (int i = 0; i < 2; i++) cnt[i] <= '0;
      db <= '1;
    end else begin
      for (int i = 0; i < 2; i++)
        if (s2[i] == db[i]) cnt[i] <= '0;
        else if (cnt[i] == CW'(DEBOUNCE_CYC - 1)) begin
          cnt[i] <= '0;
          db[i] <= ~db[i];
        end else cnt[i] <= cnt[i] + 1'b1;
    end
  assign press = armed & db_d[1] & ~db[1];
  assign rel = ~db_d[1] & db[1];
  assign clr = ~db[0];
  assign expired = tmr == TW'(1);
  always_comb begin
    state_nxt = state;
    tmr_nxt = tmr;
    inc_req = 1'b0;
    case (state)
      IDLE:
        if (press) begin
          inc_req = 1'b1;
          tmr_nxt = TW'(REPEAT_DLY);
          state_nxt = HOLD;
        end
      HOLD, REPEAT: begin
        tmr_nxt = tmr - 1'b1;
        if (rel) begin
          tmr_nxt = '0;
          state_nxt = IDLE;
        end else if (expired) begin
          inc_req = 1'b1;
          tmr_nxt = TW'(REPEAT_PER);
          state_nxt = REPEAT;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (clr) begin
      state_nxt = IDLE;
      tmr_nxt = '0;
      inc_req = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rst_i)
    if (!rst_i) begin
      state <= IDLE;
      tmr <= '0;
      led <= '0;
      inc_pulse <= 1'b0;
    end else begin
      state <= state_nxt;
      tmr <= tmr_nxt;
      led <= clr ? 4'd0 : led + 4'(inc_req);
      inc_pulse <= inc_req;
    end
endmodule

// File: tb/tb_button_count_ctrl.sv
// tb_button_count_ctrl: directed checks of debounce, repeat timing, wrap, clear and reset.
module tb_button_count_ctrl;
  logic clk = 1'b0, rst = 1'b0;
  logic [1:0] pmod = 2'b11;
  logic [3:0] led;
  logic inc_pulse;
  int checks = 0, errors = 0, pulses = 0;
  button_count_ctrl #(.DEBOUNCE_CYC(4), .REPEAT_DLY(20), .REPEAT_PER(8)) dut (
    .clk(clk), .rst(rst), .pmod(pmod), .led(led), .inc_pulse(inc_pulse)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (inc_pulse === 1'b1) pulses++;
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    pmod = 2'b11;
    rst = 1'b0;
    step(2);
    rst = 1'b1;
    step(10);
  endtask
  task automatic test_reset();
    step(3);
    checks++; if (led !== 4'd0) begin errors++; $display("FAIL reset_led got %0d want 0", led); end
    checks++; if (inc_pulse !== 1'b0) begin errors++; $display("FAIL reset_pulse got %b want 0", inc_pulse); end
    rst = 1'b1;
    step(10);
  endtask
  task automatic test_single();
    pulses = 0;
    pmod = 2'b01;
    step(6);
    checks++; if (led !== 4'd0) begin errors++; $display("FAIL single_early got %0d want 0", led); end
    step(1);
    checks++; if (led !== 4'd1) begin errors++; $display("FAIL single_led got %0d want 1", led); end
    checks++; if (inc_pulse !== 1'b1) begin errors++; $display("FAIL single_pulse got %b want 1", inc_pulse); end
    step(3);
    pmod = 2'b11;
    step(30);
    checks++; if (led !== 4'd1) begin errors++; $display("FAIL single_after got %0d want 1", led); end
    checks++; if (pulses !== 1) begin errors++; $display("FAIL single_pulses got %0d want 1", pulses); end
  endtask
  task automatic test_glitch();
    do_reset();
    pulses = 0;
    pmod = 2'b01;
    step(3);
    pmod = 2'b11;
    step(20);
    checks++; if (led !== 4'd0) begin errors++; $display("FAIL glitch_led got %0d want 0", led); end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL glitch_pulses got %0d want 0", pulses); end
  endtask
  task automatic test_repeat();
    int exp;
    do_reset();
    pulses = 0;
    pmod = 2'b01;
    for (int c = 1; c <= 60; c++) begin
      step(1);
      exp = int'(c >= 7) + int'(c >= 27) + int'(c >= 35) + int'(c >= 43) + int'(c >= 51) + int'(c >= 59);
      checks++; if (led !== 4'(exp)) begin errors++; $display("FAIL repeat_c%0d got %0d want %0d", c, led, exp); end
    end
    pmod = 2'b11;
    step(30);
    checks++; if (led !== 4'd6) begin errors++; $display("FAIL repeat_final got %0d want 6", led); end
    checks++; if (pulses !== 6) begin errors++; $display("FAIL repeat_pulses got %0d want 6", pulses); end
  endtask
  task automatic test_wrap();
    do_reset();
    for (int i = 1; i <= 17; i++) begin
      pmod = 2'b01;
      step(7);
      checks++; if (led !== 4'(i % 16)) begin errors++; $display("FAIL wrap_%0d got %0d want %0d", i, led, i % 16); end
      checks++; if (inc_pulse !== 1'b1) begin errors++; $display("FAIL wrap_pulse_%0d got %b want 1", i, inc_pulse); end
      step(3);
      pmod = 2'b11;
      step(10);
    end
  endtask
  task automatic test_clear();
    do_reset();
    pmod = 2'b01;
    step(51);
    checks++; if (led !== 4'd5) begin errors++; $display("FAIL clear_pre got %0d want 5", led); end
    pmod = 2'b00;
    step(6);
    pulses = 0;
    checks++; if (led !== 4'd5) begin errors++; $display("FAIL clear_early got %0d want 5", led); end
    step(1);
    checks++; if (led !== 4'd0) begin errors++; $display("FAIL clear_led got %0d want 0", led); end
    checks++; if (inc_pulse !== 1'b0) begin errors++; $display("FAIL clear_pulse got %b want 0", inc_pulse); end
    step(20);
    checks++; if (led !== 4'd0 || pulses !== 0) begin errors++; $display("FAIL clear_held led %0d pulses %0d want 0 0", led, pulses); end
    pmod = 2'b01;
    step(40);
    checks++; if (led !== 4'd0 || pulses !== 0) begin errors++; $display("FAIL clear_release led %0d pulses %0d want 0 0", led, pulses); end
    pmod = 2'b11;
    step(10);
    pmod = 2'b01;
    step(7);
    checks++; if (led !== 4'd1) begin errors++; $display("FAIL clear_repress got %0d want 1", led); end
    pmod = 2'b11;
    step(10);
  endtask
  task automatic test_reset_mid();
    do_reset();
    pmod = 2'b01;
    step(83);
    checks++; if (led !== 4'd9) begin errors++; $display("FAIL mid_pre got %0d want 9", led); end
    checks++; if (inc_pulse !== 1'b1) begin errors++; $display("FAIL mid_pre_pulse got %b want 1", inc_pulse); end
    #2 rst = 1'b0;
    #1;
    checks++; if (led !== 4'd0) begin errors++; $display("FAIL mid_async_led got %0d want 0", led); end
    checks++; if (inc_pulse !== 1'b0) begin errors++; $display("FAIL mid_async_pulse got %b want 0", inc_pulse); end
    step(2);
    rst = 1'b1;
    pulses = 0;
    step(60);
    checks++; if (led !== 4'd0 || pulses !== 0) begin errors++; $display("FAIL mid_held led %0d pulses %0d want 0 0", led, pulses); end
    pmod = 2'b11;
    step(12);
    pmod = 2'b01;
    step(7);
    checks++; if (led !== 4'd1) begin errors++; $display("FAIL mid_fresh got %0d want 1", led); end
  endtask
  initial begin
    test_reset();
    test_single();
    test_glitch();
    test_repeat();
    test_wrap();
    test_clear();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
